pool_window_gen: RTL
====================

# pool_window_gen

Streaming 2x2 window generator that sits directly upstream of the combinational `max_pool` reducer. It accepts one conv-layer feature map as a raster stream, one signed pixel per transfer, and buffers one even row. It emits each non-overlapping 2x2 window (stride 2) as a packed 4-pixel word in the exact `din` order `max_pool` consumes. One instance serves one feature-map channel.

## Interface

Parameters:
- `DATA_SIZE`, 16, pixel width (two's complement; passed through unmodified)
- `IMG_W`, 28, feature-map width in pixels; must be even, ≥2
- `IMG_H`, 28, feature-map height in pixels; must be even, ≥2

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  `in_data` holds a pixel
- `in_ready`  out  1  block accepts a pixel this cycle
- `in_data`  in  DATA_SIZE  pixel, raster order (row 0 col 0 first)
- `win_valid`  out  1  `win_data` holds a window
- `win_ready`  in  1  consumer accepts the window this cycle
- `win_data`  out  4*DATA_SIZE  packed window: [4D-1:3D] top-left, [3D-1:2D] top-right, [2D-1:D] bottom-left, [D-1:0] bottom-right
- `win_last`  out  1  qualifies `win_valid`; final window of the frame

## Operation

- Input transfer = `in_valid & in_ready`. Output transfer = `win_valid & win_ready`.
- Counters: `col` 0..IMG_W-1 and `row` 0..IMG_H-1 advance only on input transfer. `col` wraps to 0 and increments `row`; `row` wraps to 0 after IMG_H-1 (next frame, no gap needed).
- Even row, even col: hold pixel in `left_q`.
- Even row, odd col: write {`left_q`, `in_data`} to line-buffer entry `col>>1`.
- Odd row, even col: hold pixel in `left_q`.
- Odd row, odd col: load output register with {buf[`col>>1`], `left_q`, `in_data`}, set `win_valid`. Set `win_last` = (`row`==IMG_H-1 && `col`==IMG_W-1).
- `in_ready` = `!win_valid | win_ready` at all times, regardless of whether the current pixel produces a window. This gives a one-deep output stage with no skid and no bubble under continuous `win_ready`=1.
- `win_valid` clears on output transfer unless a new window loads in the same cycle; in that case it stays 1 with new data.
- `win_data`/`win_last` are stable while `win_valid & !win_ready`.
- Pixels are never reordered or arithmetically modified; sign is irrelevant to this block.
- Window count per frame = (IMG_W/2)*(IMG_H/2); 196 for defaults.

## Timing

- Reset values: `win_valid`=0, `win_last`=0, `win_data`=0, `in_ready`=1, `row`=`col`=0, `left_q`=0. Line-buffer contents are don't-care after reset.
- Latency: `win_valid` rises on the clock edge that accepts the bottom-right pixel; the window is visible in the next cycle.
- Throughput: one pixel per cycle with `win_ready` held 1. The output stage never stalls because windows occur at most every other pixel.
- Backpressure: while `win_valid & !win_ready`, `in_ready`=0. No pixel is accepted, so counters and the line buffer are frozen.
- `rst_n` asserted mid-frame: immediately drops `win_valid`, discards any pending window, and returns counters to row 0 col 0. The first pixel after release is treated as the top-left of a new frame.
- Invalid parameters (odd or <2 IMG_W/IMG_H) are a static check; elaboration fails.

## Structure

- Shared package `lenet_pkg`: `DATA_SIZE`, the window packing offsets (TL/TR/BL/BR slice positions), and default feature-map dimensions (C1 28x28, C3 10x10), so that `max_pool` and this block agree.
- One sub-module `pool_line_buf`:
  - depth IMG_W/2, width 2*DATA_SIZE
  - one synchronous write port, one combinational (asynchronous) read port
  - maps to distributed RAM
- Top level holds the counters, `left_q`, and the output register.
- Expected size: ~150–200 lines.

## Test plan

- IMG_W=IMG_H=4, pixels 0..15 streamed with `win_ready`=1 -> windows {0,1,4,5}, {2,3,6,7}, {8,9,12,13}, {10,11,14,15}; `win_last` only on the fourth; `in_ready` constantly 1.
- Same stream, `win_ready`=0 for 5 cycles after the first window -> `win_data`=0x0000_0001_0004_0005 held; `in_ready`=0; no pixel lost; final sequence identical.
- Negative pixels 0xFFFF, 0x8000, 0x7FFF, 0x0001 as a 2x2 frame -> `win_data`=0xFFFF_8000_7FFF_0001, bit-exact.
- Two back-to-back 4x4 frames, no gap -> 8 windows, `win_last` on the 4th and 8th; second frame's windows are correct.
- `rst_n` pulsed low after 6 pixels of a 4x4 frame, then a fresh 0..15 frame -> outputs match the first scenario; no stale window appears.
- Defaults 28x28 with random `in_valid`/`win_ready` -> 196 windows; feed each through `max_pool`; results equal a software 2x2 max-pool reference.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared LeNet constants: pixel width, window packing slots and
// feature-map sizes, so max_pool and the window generator agree.
package lenet_pkg;

    localparam int DATA_SIZE = 16;

    // Feature-map sizes feeding the two pooling layers
    localparam int C1_W = 28;
    localparam int C1_H = 28;
    localparam int C3_W = 10;
    localparam int C3_H = 10;

    // Slot index of each window pixel; slice is [slot*D +: D]
    localparam int WIN_TL = 3;
    localparam int WIN_TR = 2;
    localparam int WIN_BL = 1;
    localparam int WIN_BR = 0;

    // Position of a pixel inside its 2x2 window: {row[0], col[0]}
    typedef enum logic [1:0] {
        PH_TL = 2'b00,
        PH_TR = 2'b01,
        PH_BL = 2'b10,
        PH_BR = 2'b11
    } phase_t;

endpackage

// File: rtl/pool_window_gen_if.sv
// Pixel-in / window-out valid-ready bundle of pool_window_gen.
// slave is the generator side, master the producer/consumer side.
interface pool_window_gen_if #(
    parameter int DATA_SIZE = lenet_pkg::DATA_SIZE
);
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_SIZE-1:0]   in_data;
    logic                   win_valid;
    logic                   win_ready;
    logic [4*DATA_SIZE-1:0] win_data;
    logic                   win_last;

    modport slave (
        input  in_valid, in_data, win_ready,
        output in_ready, win_valid, win_data, win_last
    );

    modport master (
        output in_valid, in_data, win_ready,
        input  in_ready, win_valid, win_data, win_last
    );
endinterface

// File: rtl/pool_line_buf.sv
// Half-row buffer of top-row pixel pairs: synchronous write,
// combinational read, sized for distributed RAM.
module pool_line_buf #(
    parameter int DEPTH = 14,
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Store a {left,right} top-row pair; contents need no reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/pool_window_gen.sv
// Streaming 2x2 stride-2 window generator ahead of max_pool.
// Buffers one even row, emits packed {TL,TR,BL,BR} windows.
module pool_window_gen #(
    parameter int DATA_SIZE = lenet_pkg::DATA_SIZE,
    parameter int IMG_W     = lenet_pkg::C1_W,
    parameter int IMG_H     = lenet_pkg::C1_H
) (
    input logic             clk,
    input logic             rst_n,
    pool_window_gen_if.slave io_bus
);
    import lenet_pkg::*;

    localparam int D     = DATA_SIZE;
    localparam int CW    = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int DEPTH = IMG_W / 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if ((IMG_W % 2) != 0 || IMG_W < 2 ||
        (IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_dims
        $error("pool_window_gen: IMG_W/IMG_H must be even and >= 2");
    end

    logic [CW-1:0]      r_col;
    logic [RW-1:0]      r_row;
    logic [D-1:0]       r_left;
    logic               r_win_valid;
    logic               r_win_last;
    logic [4*D-1:0]     r_win_data;

    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_col_end;
    logic               w_row_end;
    phase_t             w_phase;
    logic [AW-1:0]      w_addr;
    logic               w_we;
    logic [2*D-1:0]     w_rd;
    logic [4*D-1:0]     w_pack;

    assign w_in_xfer  = io_bus.in_valid & io_bus.in_ready;
    assign w_out_xfer = r_win_valid & io_bus.win_ready;
    assign w_col_end  = (r_col == CW'(IMG_W - 1));
    assign w_row_end  = (r_row == RW'(IMG_H - 1));
    assign w_phase    = phase_t'({r_row[0], r_col[0]});
    assign w_addr     = AW'(r_col >> 1);
    assign w_we       = w_in_xfer && (w_phase == PH_TR);

    // One-deep output stage: accept whenever the slot frees this cycle
    assign io_bus.in_ready  = !r_win_valid | io_bus.win_ready;
    assign io_bus.win_valid = r_win_valid;
    assign io_bus.win_data  = r_win_data;
    assign io_bus.win_last  = r_win_last;

    pool_line_buf #(
        .DEPTH (DEPTH),
        .WIDTH (2 * D),
        .AW    (AW)
    ) u_line_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_addr),
        .i_wdata ({r_left, io_bus.in_data}),
        .i_raddr (w_addr),
        .o_rdata (w_rd)
    );

    // Assemble the window in the slot order max_pool expects
    always_comb begin
        w_pack = '0;
        w_pack[WIN_TL*D +: D] = w_rd[D +: D];
        w_pack[WIN_TR*D +: D] = w_rd[0 +: D];
        w_pack[WIN_BL*D +: D] = r_left;
        w_pack[WIN_BR*D +: D] = io_bus.in_data;
    end

    // Raster position, advanced only by accepted pixels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_in_xfer) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Hold the left pixel of each horizontal pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_left <= '0;
        end else if (w_in_xfer && !r_col[0]) begin
            r_left <= io_bus.in_data;
        end
    end

    // Output register: load on bottom-right pixel, clear on drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
            r_win_data  <= '0;
        end else if (w_in_xfer && (w_phase == PH_BR)) begin
            r_win_valid <= 1'b1;
            r_win_last  <= w_row_end && w_col_end;
            r_win_data  <= w_pack;
        end else if (w_out_xfer) begin
            r_win_valid <= 1'b0;
        end
    end
endmodule
